// File: rtl/render_pkg.sv
// Shared types and screen constants for the note rendering path.
package render_pkg;

  localparam int H_VISIBLE  = 640;
  localparam int Y_BASE     = 120;
  localparam int PITCH_STEP = 8;

  typedef struct packed {
    logic       valid;
    logic [9:0] x;
    logic [3:0] pitch;
  } note_slot_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_UPDATE,
    ST_DONE
  } sched_state_t;

  // Top scanline of a note sprite for a given staff position.
  function automatic logic [10:0] note_top(input logic [3:0] pitch);
    return 11'(Y_BASE) + 11'(pitch) * 11'(PITCH_STEP);
  endfunction

endpackage

// File: rtl/note_slot_alloc.sv
// Lowest-index-first free-slot finder over the note table valid bits.
module note_slot_alloc #(
  parameter int NUM_SLOTS = 8
) (
  input  logic [NUM_SLOTS-1:0]         valid,
  output logic                         free_found,
  output logic [$clog2(NUM_SLOTS)-1:0] free_idx
);

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    // Scan from the top so the lowest free index wins.
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_found = 1'b1;
        free_idx   = ($clog2(NUM_SLOTS))'(i);
      end
    end
  end

endmodule

// File: rtl/note_scheduler.sv
// Slot table of scrolling notes: spawns, per-frame scroll/retire pass and
// per-pixel hit lookup for the colour stage.
module note_scheduler
  import render_pkg::*;
#(
  parameter int NUM_SLOTS   = 8,
  parameter int NOTE_W      = 8,
  parameter int NOTE_H      = 6,
  parameter int SPAWN_X     = 632,
  parameter int SCROLL_STEP = 1
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         vs,
  input  logic                         scroll_en,
  input  logic                         spawn_valid,
  input  logic [3:0]                   spawn_pitch,
  output logic                         spawn_ready,
  input  logic [9:0]                   DrawX,
  input  logic [9:0]                   DrawY,
  output logic                         note_hit,
  output logic [3:0]                   note_pitch,
  output logic [$clog2(NUM_SLOTS):0]   active_count,
  output logic                         frame_tick
);

  // state     | meaning
  // ST_IDLE   | waiting for vs falling edge, spawns allowed
  // ST_UPDATE | scroll/retire slot idx, one slot per cycle
  // ST_DONE   | pass finished, frame_tick high

  localparam int IDX_W = $clog2(NUM_SLOTS);
  localparam int CNT_W = IDX_W + 1;

  note_slot_t           slots [NUM_SLOTS];
  sched_state_t         state;
  logic [IDX_W-1:0]     idx;
  logic                 vs_d;
  logic                 frame_start;
  logic [NUM_SLOTS-1:0] valid_vec;
  logic                 free_found;
  logic [IDX_W-1:0]     free_idx;
  logic                 hit_c;
  logic [3:0]           pitch_c;
  logic [CNT_W-1:0]     count_c;

  assign frame_start = vs_d & ~vs;
  assign spawn_ready = (state == ST_IDLE) && free_found;

  always_comb begin
    valid_vec = '0;
    count_c   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      valid_vec[i] = slots[i].valid;
      count_c      = count_c + CNT_W'(slots[i].valid);
    end
  end

  note_slot_alloc #(.NUM_SLOTS(NUM_SLOTS)) u_alloc (
    .valid      (valid_vec),
    .free_found (free_found),
    .free_idx   (free_idx)
  );

  // 11-bit compares keep x+NOTE_W and y+NOTE_H from wrapping.
  function automatic logic slot_hit(input note_slot_t s, input logic [9:0] px,
                                    input logic [9:0] py);
    logic [10:0] x0;
    logic [10:0] y0;
    x0 = {1'b0, s.x};
    y0 = note_top(s.pitch);
    return s.valid && ({1'b0, px} < 11'(H_VISIBLE)) &&
           ({1'b0, px} >= x0) && ({1'b0, px} < x0 + 11'(NOTE_W)) &&
           ({1'b0, py} >= y0) && ({1'b0, py} < y0 + 11'(NOTE_H));
  endfunction

  always_comb begin
    hit_c   = 1'b0;
    pitch_c = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (slot_hit(slots[i], DrawX, DrawY)) begin
        hit_c   = 1'b1;
        pitch_c = slots[i].pitch;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      vs_d       <= 1'b1;
      frame_tick <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) slots[i] <= '0;
    end else begin
      vs_d       <= vs;
      frame_tick <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (spawn_valid && spawn_ready)
            slots[free_idx] <= '{valid: 1'b1, x: 10'(SPAWN_X), pitch: spawn_pitch};
          if (frame_start) begin
            state <= ST_UPDATE;
            idx   <= '0;
          end
        end
        ST_UPDATE: begin
          if (slots[idx].valid && scroll_en) begin
            if (slots[idx].x < 10'(SCROLL_STEP))
              slots[idx].valid <= 1'b0;
            else
              slots[idx].x <= slots[idx].x - 10'(SCROLL_STEP);
          end
          if (idx == IDX_W'(NUM_SLOTS - 1)) begin
            state      <= ST_DONE;
            frame_tick <= 1'b1;
          end
          idx <= idx + IDX_W'(1);
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      note_hit     <= 1'b0;
      note_pitch   <= '0;
      active_count <= '0;
    end else begin
      note_hit     <= hit_c;
      note_pitch   <= pitch_c;
      active_count <= count_c;
    end
  end

endmodule

// File: tb/tb_note_scheduler.sv
// Bench for note_scheduler: directed scenarios plus randomized spawn/frame/probe
// traffic checked against a per-frame behavioural model of the note table.
module tb_note_scheduler;

  localparam int NS = 8;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       vs, scroll_en, spawn_valid;
  logic [3:0] spawn_pitch;
  logic       spawn_ready;
  logic [9:0] DrawX, DrawY;
  logic       note_hit;
  logic [3:0] note_pitch;
  logic [3:0] active_count;
  logic       frame_tick;

  int total = 0;
  int bad   = 0;

  bit m_valid [NS];
  int m_x     [NS];
  int m_pitch [NS];

  always #5 Clk = ~Clk;

  note_scheduler dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .vs           (vs),
    .scroll_en    (scroll_en),
    .spawn_valid  (spawn_valid),
    .spawn_pitch  (spawn_pitch),
    .spawn_ready  (spawn_ready),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .note_hit     (note_hit),
    .note_pitch   (note_pitch),
    .active_count (active_count),
    .frame_tick   (frame_tick)
  );

  function automatic void m_clear();
    for (int i = 0; i < NS; i++) begin
      m_valid[i] = 0; m_x[i] = 0; m_pitch[i] = 0;
    end
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < NS; i++) if (m_valid[i]) c++;
    return c;
  endfunction

  function automatic int m_free();
    for (int i = 0; i < NS; i++) if (!m_valid[i]) return i;
    return -1;
  endfunction

  function automatic void m_spawn(int p);
    int f;
    f = m_free();
    if (f >= 0) begin
      m_valid[f] = 1; m_x[f] = 632; m_pitch[f] = p;
    end
  endfunction

  function automatic void m_frame(bit s);
    for (int i = 0; i < NS; i++) begin
      if (m_valid[i] && s) begin
        if (m_x[i] < 1) m_valid[i] = 0;
        else m_x[i] = m_x[i] - 1;
      end
    end
  endfunction

  function automatic void m_hit(int dx, int dy, output bit h, output int p);
    int top;
    h = 0; p = 0;
    for (int i = 0; i < NS; i++) begin
      top = 120 + 8 * m_pitch[i];
      if (!h && m_valid[i] && dx >= m_x[i] && dx < m_x[i] + 8 && dy >= top && dy < top + 6) begin
        h = 1; p = m_pitch[i];
      end
    end
  endfunction

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic do_reset();
    Reset = 1; vs = 1; scroll_en = 1; spawn_valid = 0; spawn_pitch = 0; DrawX = 0; DrawY = 0;
    tick(); tick();
    Reset = 0;
    m_clear();
    tick();
  endtask

  task automatic probe(int x, int y, output bit h, output logic [3:0] p);
    DrawX = 10'(x); DrawY = 10'(y);
    tick();
    h = note_hit; p = note_pitch;
  endtask

  task automatic spawn_one(int p, output bit rdy);
    spawn_valid = 1; spawn_pitch = 4'(p);
    rdy = spawn_ready;
    tick();
    spawn_valid = 0;
    if (rdy) m_spawn(p);
  endtask

  // Drives one vs falling edge and watches 13 cycles; sample n counts cycles after the edge cycle.
  task automatic run_frame(input bit scroll, input bit spawn, input bit hold, input int p,
                           output int tick_pos, output int tick_cnt, output int ready_low,
                           output int count_mid);
    bit acc;
    tick_pos = 0; tick_cnt = 0; ready_low = 0; count_mid = -1;
    vs = 0; scroll_en = scroll; spawn_pitch = 4'(p); spawn_valid = spawn;
    for (int n = 0; n <= 12; n++) begin
      acc = spawn_valid && spawn_ready;
      tick();
      if (n == 0) vs = 1;
      if (acc) begin
        m_spawn(p); spawn_valid = 0;
      end else if (!hold && n == 0) begin
        spawn_valid = 0;
      end
      if (n + 1 == 9) m_frame(scroll);
      if (n + 1 == 10) count_mid = active_count;
      if (frame_tick) begin
        tick_cnt++;
        if (tick_pos == 0) tick_pos = n + 1;
      end
      if (!spawn_ready) ready_low++;
    end
  endtask

  task automatic test_reset();
    Reset = 1; vs = 1; scroll_en = 1; spawn_valid = 0; spawn_pitch = 0; DrawX = 0; DrawY = 0;
    m_clear();
    repeat (2) @(posedge Clk);
    #1;
    total++; if (note_hit !== 1'b0) begin bad++; $display("FAIL reset_hit got=%b want=0", note_hit); end
    total++; if (note_pitch !== 4'd0) begin bad++; $display("FAIL reset_pitch got=%0d want=0", note_pitch); end
    total++; if (active_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", active_count); end
    total++; if (frame_tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b want=0", frame_tick); end
    Reset = 0;
    total++; if (spawn_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", spawn_ready); end
    tick();
    total++; if (active_count !== 4'd0 || frame_tick !== 1'b0) begin bad++; $display("FAIL reset_idle got cnt=%0d tick=%b want 0/0", active_count, frame_tick); end
  endtask

  task automatic test_spawn_hit();
    bit rdy, h, eh;
    logic [3:0] p;
    int ep, tp, tc, rl, cm;
    int px [6] = '{631, 639, 630, 638, 638, 635};
    int py [6] = '{144, 144, 144, 149, 150, 143};
    do_reset();
    spawn_one(3, rdy);
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL spawn_ready got=%b want=1", rdy); end
    run_frame(1, 0, 0, 0, tp, tc, rl, cm);
    total++; if (tp != 9 || tc != 1) begin bad++; $display("FAIL frame_tick_timing got pos=%0d cnt=%0d want 9/1", tp, tc); end
    total++; if (rl != 9) begin bad++; $display("FAIL ready_low_cycles got=%0d want=9", rl); end
    total++; if (cm != 1) begin bad++; $display("FAIL count_after_frame got=%0d want=1", cm); end
    for (int k = 0; k < 6; k++) begin
      probe(px[k], py[k], h, p);
      m_hit(px[k], py[k], eh, ep);
      total++; if (h !== eh || p !== 4'(ep)) begin bad++; $display("FAIL spawn_probe(%0d,%0d) got hit=%b pitch=%0d want hit=%b pitch=%0d", px[k], py[k], h, p, eh, ep); end
    end
    probe(631, 144, h, p);
    total++; if (h !== 1'b1 || p !== 4'd3) begin bad++; $display("FAIL spawn_hit_631 got hit=%b pitch=%0d want 1/3", h, p); end
  endtask

  task automatic test_simultaneous();
    bit h;
    logic [3:0] p;
    int tp, tc, rl, cm;
    do_reset();
    run_frame(1, 1, 0, 7, tp, tc, rl, cm);
    total++; if (tp != 9 || tc != 1) begin bad++; $display("FAIL simul_tick got pos=%0d cnt=%0d want 9/1", tp, tc); end
    total++; if (cm != 1 || active_count !== 4'(m_count())) begin bad++; $display("FAIL simul_count got mid=%0d now=%0d want 1", cm, active_count); end
    probe(631, 176, h, p);
    total++; if (h !== 1'b1 || p !== 4'd7) begin bad++; $display("FAIL simul_hit_631 got hit=%b pitch=%0d want 1/7", h, p); end
    probe(639, 176, h, p);
    total++; if (h !== 1'b0) begin bad++; $display("FAIL simul_miss_639 got hit=%b want 0", h); end
  endtask

  task automatic test_priority_reset();
    bit rdy, h, eh;
    logic [3:0] p;
    int ep, tp, tc, rl, cm;
    int px [3] = '{635, 631, 639};
    do_reset();
    spawn_one(0, rdy);
    spawn_one(5, rdy);
    run_frame(1, 0, 0, 0, tp, tc, rl, cm);
    spawn_one(5, rdy);
    for (int k = 0; k < 3; k++) begin
      probe(px[k], 162, h, p);
      m_hit(px[k], 162, eh, ep);
      total++; if (h !== eh || p !== 4'(ep)) begin bad++; $display("FAIL prio_probe(%0d) got hit=%b pitch=%0d want hit=%b pitch=%0d", px[k], h, p, eh, ep); end
    end
    total++; if (active_count !== 4'd3) begin bad++; $display("FAIL prio_count got=%0d want=3", active_count); end
    // abort a pass part-way through with reset
    vs = 0; tick(); vs = 1; tick(); tick();
    Reset = 1; #1;
    total++; if (active_count !== 4'd0 || spawn_ready !== 1'b1) begin bad++; $display("FAIL midreset_async got cnt=%0d ready=%b want 0/1", active_count, spawn_ready); end
    tick();
    Reset = 0; m_clear();
    tick();
    total++; if (spawn_ready !== 1'b1 || active_count !== 4'd0) begin bad++; $display("FAIL midreset_release got ready=%b cnt=%0d want 1/0", spawn_ready, active_count); end
    probe(635, 160, h, p);
    total++; if (h !== 1'b0) begin bad++; $display("FAIL midreset_nohit got hit=%b want 0", h); end
    run_frame(1, 0, 0, 0, tp, tc, rl, cm);
    total++; if (tp != 9 || tc != 1) begin bad++; $display("FAIL midreset_frame got pos=%0d cnt=%0d want 9/1", tp, tc); end
  endtask

  task automatic test_full_retire();
    bit rdy, h, eh;
    logic [3:0] p;
    int ep, tp, tc, rl, cm, leaks;
    do_reset();
    spawn_one(2, rdy);
    run_frame(1, 0, 0, 0, tp, tc, rl, cm);
    spawn_valid = 1;
    for (int k = 1; k < NS; k++) begin
      spawn_pitch = 4'(k + 3);
      total++; if (spawn_ready !== 1'b1) begin bad++; $display("FAIL full_b2b_ready[%0d] got=%b want=1", k, spawn_ready); end
      tick();
      m_spawn(k + 3);
    end
    spawn_pitch = 4'd9;
    total++; if (spawn_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", spawn_ready); end
    tick();
    total++; if (active_count !== 4'd8 || spawn_ready !== 1'b0) begin bad++; $display("FAIL full_count got cnt=%0d ready=%b want 8/0", active_count, spawn_ready); end
    leaks = 0;
    for (int f = 0; f < 631; f++) begin
      run_frame(1, 1, 1, 9, tp, tc, rl, cm);
      if (rl != 13 || tc != 1 || cm != 8) leaks++;
    end
    total++; if (leaks != 0 || spawn_valid !== 1'b1) begin bad++; $display("FAIL full_pending_held got bad_frames=%0d pending=%b want 0/1", leaks, spawn_valid); end
    run_frame(1, 1, 1, 9, tp, tc, rl, cm);
    total++; if (cm != 7) begin bad++; $display("FAIL retire_count_drop got=%0d want=7", cm); end
    total++; if (spawn_valid !== 1'b0) begin bad++; $display("FAIL retire_pending_accept got pending=%b want 0", spawn_valid); end
    total++; if (tp != 9 || active_count !== 4'(m_count())) begin bad++; $display("FAIL retire_after got tick=%0d cnt=%0d want 9/%0d", tp, active_count, m_count()); end
    probe(632, 192, h, p);
    m_hit(632, 192, eh, ep);
    total++; if (h !== eh || p !== 4'(ep)) begin bad++; $display("FAIL retire_newnote got hit=%b pitch=%0d want hit=%b pitch=%0d", h, p, eh, ep); end
    probe(0, 152, h, p);
    m_hit(0, 152, eh, ep);
    total++; if (h !== eh || p !== 4'(ep)) begin bad++; $display("FAIL retire_edge_x0 got hit=%b pitch=%0d want hit=%b pitch=%0d", h, p, eh, ep); end
  endtask

  task automatic test_random();
    bit rdy, erdy, h, eh;
    logic [3:0] p;
    int ep, tp, tc, rl, cm, r, i, x, y;
    do_reset();
    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(0, 4);
      if (r == 0) begin
        erdy = (m_free() >= 0);
        spawn_one($urandom_range(0, 15), rdy);
        total++; if (rdy !== erdy) begin bad++; $display("FAIL rand_ready it=%0d got=%b want=%b", it, rdy, erdy); end
      end else if (r == 1) begin
        run_frame($urandom_range(0, 1), $urandom_range(0, 1), 0, $urandom_range(0, 15), tp, tc, rl, cm);
        total++; if (tp != 9 || tc != 1 || cm != m_count()) begin bad++; $display("FAIL rand_frame it=%0d got tick=%0d/%0d cnt=%0d want 9/1/%0d", it, tp, tc, cm, m_count()); end
      end else begin
        i = $urandom_range(0, NS - 1);
        if (m_valid[i]) begin
          x = m_x[i] + $urandom_range(0, 11) - 2;
          y = 120 + 8 * m_pitch[i] + $urandom_range(0, 9) - 2;
        end else begin
          x = $urandom_range(0, 639);
          y = $urandom_range(100, 260);
        end
        if (x < 0) x = 0;
        probe(x, y, h, p);
        m_hit(x, y, eh, ep);
        total++; if (h !== eh || p !== 4'(ep)) begin bad++; $display("FAIL rand_probe it=%0d (%0d,%0d) got hit=%b pitch=%0d want hit=%b pitch=%0d", it, x, y, h, p, eh, ep); end
        total++; if (active_count !== 4'(m_count())) begin bad++; $display("FAIL rand_count it=%0d got=%0d want=%0d", it, active_count, m_count()); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_spawn_hit();
    test_simultaneous();
    test_priority_reset();
    test_full_retire();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/note_scheduler.md
# note_scheduler

Slot-based scheduler for the scrolling notes on the staff display. It accepts note-spawn requests, stores up to `NUM_SLOTS` active notes, and scrolls every note left once per video frame, retiring notes that leave the screen. It answers per-pixel "is a note here" queries from the colour stage alongside the staff-line (`ledger`) overlay. It runs in the VGA pixel-clock domain and takes `vs`, `DrawX` and `DrawY` from `vga_controller`.

## Interface
- `NUM_SLOTS`, 8: note table depth, a power of two.
- `NOTE_W`, 8: note sprite width in pixels.
- `NOTE_H`, 6: note sprite height in pixels.
- `SPAWN_X`, 632: x coordinate given to a newly spawned note.
- `SCROLL_STEP`, 1: pixels moved left per frame, range 1..15.
- `Clk`  in  1  pixel clock, the only clock.
- `Reset`  in  1  asynchronous, active-high; clears all state.
- `vs`  in  1  vertical sync from `vga_controller`, active-low.
- `scroll_en`  in  1  1 = scroll on each frame; 0 = freeze positions, frame tick still issued.
- `spawn_valid`  in  1  spawn request.
- `spawn_pitch`  in  4  staff position of the requested note, 0..15.
- `spawn_ready`  out  1  spawn accepted when high together with `spawn_valid`.
- `DrawX`, `DrawY`  in  10  current pixel coordinates.
- `note_hit`  out  1  registered; pixel (`DrawX`, `DrawY`) from the previous cycle lies inside an active note.
- `note_pitch`  out  4  registered; pitch of the hitting slot, 0 when no hit.
- `active_count`  out  log2(`NUM_SLOTS`)+1  number of valid slots.
- `frame_tick`  out  1  one-cycle pulse when a scroll pass completes.

## Operation
- Each slot holds `valid`, `x` (10 bits) and `pitch` (4 bits). The note's top y is `Y_BASE` + `pitch`*`PITCH_STEP`, with `Y_BASE`=120 and `PITCH_STEP`=8.
- Edge detection: `vs_d` is `vs` registered, reset value 1. A frame start is `vs_d & ~vs`, the falling edge of `vs`.
- FSM states and transitions:
  - IDLE: a frame start moves to UPDATE with `idx`=0.
  - UPDATE: processes slot `idx`, one slot per cycle. After `idx`=`NUM_SLOTS`-1 it moves to DONE.
  - DONE: pulses `frame_tick` and returns to IDLE.
- Slot update in UPDATE, valid slots only:
  - If `scroll_en`=0, the slot is unchanged.
  - Else if `x` < `SCROLL_STEP`, clear `valid` (retire).
  - Else `x` <= `x` - `SCROLL_STEP`. There is no underflow wrap.
- Spawn rules:
  - `spawn_ready` = (state==IDLE) && (a free slot exists). It is combinational.
  - On `spawn_valid && spawn_ready`, the lowest-indexed free slot is written with `valid`=1, `x`=`SPAWN_X` and `pitch`=`spawn_pitch`.
  - A request held while `spawn_ready`=0 is not lost; it waits.
- Spawn and frame start in the same IDLE cycle: the spawn is written that cycle, UPDATE starts the next cycle, and the new note is scrolled in that pass.
- Hit test, combinational then registered:
  - Slot i hits when `valid` && `x` <= `DrawX` < `x`+`NOTE_W` && y <= `DrawY` < y+`NOTE_H`.
  - Compares use 11-bit sums so `x`+`NOTE_W` cannot overflow.
  - When several slots hit, the lowest index supplies `note_pitch`.
- Hit queries run during UPDATE using the table's current contents. UPDATE falls in vertical blanking, so no tearing is visible.
- `active_count` is a registered popcount of `valid`, updated every cycle.

## Timing
- Reset values:
  - All slots invalid, state IDLE, `idx`=0.
  - `note_hit`=0, `note_pitch`=0, `active_count`=0, `frame_tick`=0.
  - `spawn_ready`=1 once `Reset` is released.
- Hit latency is 1 cycle from `DrawX`/`DrawY` to `note_hit`/`note_pitch`.
- A frame start at cycle t gives UPDATE in cycles t+1..t+`NUM_SLOTS`, DONE and `frame_tick`=1 at t+`NUM_SLOTS`+1, and IDLE after that.
- `spawn_ready` is 0 for `NUM_SLOTS`+1 cycles per frame.
- A frame start seen outside IDLE is ignored. This cannot occur at VGA rates.
- Reset asserted mid-UPDATE clears every slot immediately; there is no partial pass.
- `active_count` lags a spawn or retire by 1 cycle.

## Structure
- Shared package `render_pkg` holds:
  - the `note_slot_t` struct (`valid`, `x`, `pitch`);
  - the scheduler state enum;
  - the constants `H_VISIBLE`=640, `Y_BASE`, `PITCH_STEP`.
- Sub-module `note_slot_alloc`: a lowest-index-first priority encoder over the `valid` vector. It outputs `free_found` and `free_idx`.

## Test plan
- Spawn / hit: after reset, spawn pitch 3, then drive one `vs` falling edge with `scroll_en`=1. Required: slot0 `x`=631; probe (631,144) gives `note_hit`=1 and `note_pitch`=3 one cycle later; probe (639,144) gives `note_hit`=0.
- Full table: spawn 8 notes back-to-back. Required: `spawn_ready`=0 and `active_count`=8. A 9th request stays pending until a retire, then it is accepted.
- Retire: force slot0 `x`=0, then a frame start. Required: `valid` cleared and `active_count` drops by 1.
- Simultaneous events: spawn in the same cycle as a `vs` falling edge. Required: the new note ends at `x`=631, and `frame_tick` pulses exactly `NUM_SLOTS`+1 cycles after the edge.
- Priority and reset: two overlapping notes in slots 1 and 2 with pitches 5 and 5 but different `x` positions. The hit reports slot 1's pitch. Asserting `Reset` mid-UPDATE gives all slots invalid and `spawn_ready`=1 after release.
